// File: rtl/restador_serial_8bits_if.sv
// Start/busy/done handshake and operand/result bus for the bit-serial subtractor.
// The requester owns the master side; the subtractor owns the slave side.
interface restador_serial_8bits_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A8;
  logic [WIDTH-1:0] B8;
  logic             Borrow_i;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   D8;

  modport master (
    output start, A8, B8, Borrow_i,
    input  busy, done, D8
  );

  modport slave (
    input  start, A8, B8, Borrow_i,
    output busy, done, D8
  );
endinterface

// File: rtl/restador_serial_8bits.sv
// Bit-serial subtractor: D8 = {borrow, A8 - B8 - Borrow_i}, one bit per clock, LSB first.
// Companion of the parallel adder; result is published with a one-cycle done pulse.
module restador_serial_8bits #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  restador_serial_8bits_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] diff_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   d8_q;

  logic             a_i;
  logic             b_i;
  logic             d_i;
  logic             br_nxt;
  logic             last_bit;
  logic [WIDTH-1:0] diff_shifted;

  assign a_i          = a_sr[0];
  assign b_i          = b_sr[0];
  assign d_i          = a_i ^ b_i ^ br;
  assign br_nxt       = (~a_i & b_i) | (~(a_i ^ b_i) & br);
  assign last_bit     = (cnt == CW'(WIDTH - 1));
  // diff_sr only keeps the WIDTH-1 earlier bits; the final bit joins them on the last edge
  assign diff_shifted = {d_i, diff_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = SHIFT;
      SHIFT:   if (last_bit)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      br      <= 1'b0;
      cnt     <= '0;
      d8_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr <= bus.A8;
            b_sr <= bus.B8;
            br   <= bus.Borrow_i;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          br      <= br_nxt;
          diff_sr <= diff_shifted[WIDTH-1:1];
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            d8_q <= {br_nxt, diff_shifted};
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode straight from flops, so nothing on the request side reaches them combinationally
  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.D8   = d8_q;

endmodule

// File: tb/tb_restador_serial_8bits.sv
// Directed and table-driven checks for the bit-serial subtractor, including
// busy-time start rejection, mid-operation reset and back-to-back throughput.
module tb_restador_serial_8bits;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  restador_serial_8bits_if #(.WIDTH(WIDTH)) bus ();

  restador_serial_8bits #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic [WIDTH:0]   exp;
  } vec_t;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Issues one start pulse, scrambles the operands after capture and follows the operation.
  // lat is the number of edges after the accept edge until done is seen (-1 if never).
  task automatic applyStimulus(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bi,
    output logic [WIDTH:0]   res,
    output int               lat,
    output int               busy_cnt,
    output int               done_cnt,
    output int               early_chg
  );
    logic [WIDTH:0] d8_prev;
    @(negedge clk);
    d8_prev      = bus.D8;
    bus.A8       = a;
    bus.B8       = b;
    bus.Borrow_i = bi;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.A8       = ~a;
    bus.B8       = ~b;
    bus.Borrow_i = ~bi;
    res       = '0;
    lat       = -1;
    busy_cnt  = 0;
    done_cnt  = 0;
    early_chg = 0;
    for (int e = 0; e < WIDTH + 4; e++) begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = e;
          res = bus.D8;
        end
      end else if (lat < 0 && bus.D8 !== d8_prev) begin
        early_chg++;
      end
      @(negedge clk);
    end
  endtask

  vec_t           vecs[10];
  logic [WIDTH:0] res;
  logic [WIDTH:0] exp_r;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic           rbi;
  int             lat;
  int             busy_cnt;
  int             done_cnt;
  int             early_chg;
  int             done_at[$];

  initial begin
    vecs[0] = '{a: 8'h0F, b: 8'h0F, bi: 1'b0, exp: 9'h000};
    vecs[1] = '{a: 8'h33, b: 8'h11, bi: 1'b0, exp: 9'h022};
    vecs[2] = '{a: 8'h00, b: 8'h01, bi: 1'b0, exp: 9'h1FF};
    vecs[3] = '{a: 8'hFF, b: 8'hFF, bi: 1'b1, exp: 9'h1FF};
    vecs[4] = '{a: 8'h77, b: 8'h33, bi: 1'b0, exp: 9'h044};
    vecs[5] = '{a: 8'h80, b: 8'h01, bi: 1'b0, exp: 9'h07F};
    vecs[6] = '{a: 8'h00, b: 8'h00, bi: 1'b1, exp: 9'h1FF};
    vecs[7] = '{a: 8'hFF, b: 8'h00, bi: 1'b0, exp: 9'h0FF};
    vecs[8] = '{a: 8'h10, b: 8'h20, bi: 1'b1, exp: 9'h1EF};
    vecs[9] = '{a: 8'hAA, b: 8'h55, bi: 1'b1, exp: 9'h054};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.A8       = '0;
    bus.B8       = '0;
    bus.Borrow_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset D8",   32'(bus.D8),   32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bi, res, lat, busy_cnt, done_cnt, early_chg);
      checkOutput($sformatf("vec%0d D8", i),          32'(res),      32'(vecs[i].exp));
      checkOutput($sformatf("vec%0d latency", i),     32'(lat),      32'(WIDTH));
      checkOutput($sformatf("vec%0d busy cycles", i), 32'(busy_cnt), 32'(WIDTH + 1));
      checkOutput($sformatf("vec%0d done pulses", i), 32'(done_cnt), 32'd1);
      checkOutput($sformatf("vec%0d D8 early", i),    32'(early_chg), 32'd0);
      checkOutput($sformatf("vec%0d D8 held", i),     32'(bus.D8),   32'(vecs[i].exp));
    end

    // Second start with new operands in the third busy cycle must be ignored
    @(negedge clk);
    bus.A8 = 8'h33; bus.B8 = 8'h11; bus.Borrow_i = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.A8 = 8'hFF; bus.B8 = 8'h00; bus.Borrow_i = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    done_cnt = 0;
    res = '0;
    for (int k = 0; k < 14; k++) begin
      if (bus.done) begin
        done_cnt++;
        res = bus.D8;
      end
      @(negedge clk);
    end
    checkOutput("busy-start done pulses", 32'(done_cnt), 32'd1);
    checkOutput("busy-start D8",          32'(res),      32'h022);
    checkOutput("busy-start idle",        32'(bus.busy), 32'd0);

    // Asynchronous reset after four SHIFT edges
    @(negedge clk);
    bus.A8 = 8'h5A; bus.B8 = 8'h3C; bus.Borrow_i = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    checkOutput("abort D8",   32'(bus.D8),   32'd0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_cnt++;
    end
    checkOutput("abort quiet", 32'(done_cnt), 32'd0);
    rst_n = 1'b1;
    applyStimulus(8'h77, 8'h33, 1'b0, res, lat, busy_cnt, done_cnt, early_chg);
    checkOutput("post-reset D8",      32'(res), 32'h044);
    checkOutput("post-reset latency", 32'(lat), 32'(WIDTH));

    // start held high: one result every WIDTH+2 cycles (200 - 100 - 1 = 99)
    @(negedge clk);
    bus.A8 = 8'hC8; bus.B8 = 8'h64; bus.Borrow_i = 1'b1; bus.start = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (bus.done) begin
        done_at.push_back(k);
        checkOutput($sformatf("b2b D8 @%0d", k), 32'(bus.D8), 32'h063);
      end
    end
    bus.start = 1'b0;
    repeat (WIDTH + 4) @(negedge clk);
    checkOutput("b2b pulse count", 32'(done_at.size()), 32'd4);
    if (done_at.size() > 0) checkOutput("b2b first done", 32'(done_at[0]), 32'(WIDTH));
    for (int i = 1; i < done_at.size(); i++) begin
      checkOutput($sformatf("b2b interval %0d", i), 32'(done_at[i] - done_at[i-1]), 32'(WIDTH + 2));
    end

    // Random sweep against the unsigned subtraction model
    for (int i = 0; i < 16; i++) begin
      ra    = WIDTH'($urandom);
      rb    = WIDTH'($urandom);
      rbi   = 1'($urandom_range(1));
      exp_r = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbi};
      applyStimulus(ra, rb, rbi, res, lat, busy_cnt, done_cnt, early_chg);
      checkOutput($sformatf("rand%0d %0h-%0h-%0d", i, ra, rb, rbi), 32'(res), 32'(exp_r));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
